// File: rtl/divider_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned DIV_DW = 8;
  localparam int unsigned DIV_VW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DIV_CW = cnt_width(DIV_DW);

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module divider_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_o,
  output logic          q_o
);

  logic [VW:0] r_sh;
  logic [VW:0] dvs_ext;

  assign r_sh    = {r_i[VW-1:0], bit_i};
  assign dvs_ext = {1'b0, divisor_i};

  // r_i[VW] set means the true shifted value exceeds VW+1 bits, so it always fits;
  // the modular subtraction below still yields the exact remainder in that case.
  always_comb begin
    q_o = r_i[VW] | (r_sh >= dvs_ext);
    r_o = q_o ? (r_sh - dvs_ext) : r_sh;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both ends.
// Optional macro DIVIDER_DIV0_TRAP_EN: divisor 0 bypasses BUSY and flags div0.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div0,
  output logic          busy
);

  localparam int unsigned CW = cnt_width(DW);

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;

  logic [VW:0]   step_r;
  logic          step_q;

  divider_step #(
    .VW (VW)
  ) u_step (
    .r_i       (r_q),
    .bit_i     (dvd_q[DW-1]),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef DIVIDER_DIV0_TRAP_EN
          state_d = (divisor == '0) ? DONE : BUSY;
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
  end

`ifdef DIVIDER_DIV0_TRAP_EN
  logic div0_q, div0_d;
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  // The dividend register doubles as the quotient accumulator: each step
  // shifts out the consumed MSB and shifts the new quotient bit into the LSB.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
`ifdef DIVIDER_DIV0_TRAP_EN
    div0_d = div0_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          r_d   = '0;
          cnt_d = CW'(DW - 1);
`ifdef DIVIDER_DIV0_TRAP_EN
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = dividend[VW-1:0];
            div0_d = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        r_d   = step_r;
        dvd_d = {dvd_q[DW-2:0], step_q};
        if (cnt_q == '0) begin
          quot_d = {dvd_q[DW-2:0], step_q};
          rem_d  = step_r[VW-1:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
`ifdef DIVIDER_DIV0_TRAP_EN
        if (out_ready) begin
          div0_d = 1'b0;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
`ifdef DIVIDER_DIV0_TRAP_EN
      div0_q <= 1'b0;
`endif
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
`ifdef DIVIDER_DIV0_TRAP_EN
      div0_q <= div0_d;
`endif
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks for seq_restoring_divider at default widths (8/4).
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div0;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(
    .DW (8),
    .VW (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the divider idle; leaves #1 after the
  // edge on which the result was handed off.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er,
                       input int exp_lat, input logic exp_div0);
    int lat;
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'hA5;
    divisor  = 4'hF;
    if (exp_lat > 0) begin
      check("busy_after_accept", busy, 1);
      check("in_ready_while_busy", in_ready, 0);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div0", div0, exp_div0);
    @(posedge clk); #1;
    check("out_valid_after_handoff", out_valid, 0);
    check("in_ready_after_handoff", in_ready, 1);
    check("quotient_kept", quotient, eq);
  endtask

  logic [7:0] bb_a [3] = '{8'd50, 8'd13, 8'd240};
  logic [3:0] bb_b [3] = '{4'd6, 4'd13, 4'd11};
  logic [7:0] bb_q [3] = '{8'd8, 8'd1, 8'd21};
  logic [3:0] bb_r [3] = '{4'd2, 4'd0, 4'd9};

  initial begin
    int cyc, acc_idx, res_idx, last_acc, tmo, t;
    logic pre_ready, got, seen;
    logic [7:0] ra, mq;
    logic [3:0] rb, mr;

    // Reset values while reset is held
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div0", div0, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1);

    do_op(8'd200, 4'd7, 8'd28, 4'd4, 8, 1'b0);
    do_op(8'd255, 4'd15, 8'd17, 4'd0, 8, 1'b0);
    do_op(8'd5, 4'd9, 8'd0, 4'd5, 8, 1'b0);
`ifdef DIVIDER_DIV0_TRAP_EN
    // Trap result is already presented right after the accepting edge.
    do_op(8'd100, 4'd0, 8'd255, 4'd4, 0, 1'b1);
    check("div0_cleared", div0, 0);
`else
    do_op(8'd100, 4'd0, 8'd255, 4'd4, 8, 1'b0);
`endif

    // Backpressure: 77/3 held while out_ready is low
    in_valid = 1'b1; dividend = 8'd77; divisor = 4'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_latency", t, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid_held", out_valid, 1);
      check("bp_quotient_held", quotient, 25);
      check("bp_remainder_held", remainder, 2);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Back-to-back with in_valid held high
    cyc = 0; acc_idx = 0; res_idx = 0; last_acc = 0;
    in_valid = 1'b1; dividend = bb_a[0]; divisor = bb_b[0]; out_ready = 1'b1;
    while (res_idx < 3 && cyc < 100) begin
      pre_ready = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (pre_ready && acc_idx < 3) begin
        if (acc_idx > 0) check("b2b_accept_spacing", cyc - last_acc, 10);
        last_acc = cyc;
        acc_idx++;
        if (acc_idx < 3) begin
          dividend = bb_a[acc_idx];
          divisor  = bb_b[acc_idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check("b2b_quotient", quotient, bb_q[res_idx]);
        check("b2b_remainder", remainder, bb_r[res_idx]);
        res_idx++;
      end
    end
    check("b2b_results_seen", res_idx, 3);

    // Reset pulse in the 4th BUSY cycle of 123/5
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = 8'd123; divisor = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div0", div0, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    do_op(8'd9, 4'd2, 8'd4, 4'd1, 8, 1'b0);

    // Random sweep with random output stalls
    tmo = 0;
    for (int n = 0; n < 2000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(0, 15));
      mq = (rb == 0) ? 8'd255 : ra / {4'd0, rb};
      mr = (rb == 0) ? ra[3:0] : 4'(ra % {4'd0, rb});
      in_valid = 1'b1; dividend = ra; divisor = rb;
      t = 0;
      while (!in_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 8'($urandom_range(0, 255));
      divisor  = 4'($urandom_range(0, 15));
      got = 1'b0; seen = 1'b0; t = 0;
      while (!got && t < 60) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid) begin
          if (!seen) begin
            check("rand_quotient", quotient, mq);
            check("rand_remainder", remainder, mr);
            if (rb != 0) begin
              check("rand_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
              check("rand_rem_lt_div", 32'(remainder < rb), 1);
            end
            seen = 1'b1;
          end
          if (out_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        t++;
      end
      if (!got) tmo++;
    end
    check("rand_timeouts", tmo, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative restoring divider: DW-bit unsigned dividend / VW-bit unsigned divisor -> DW-bit quotient, VW-bit remainder.
- Inverse arithmetic companion to the pipelined Dadda multiplier; default widths 8/4 match its 8-bit product and 4-bit operand.
- One quotient bit per clock.
- Valid/ready handshake on both ends, so it drops into the same datapath as the multiplier.

Parameters:
- DW, 8, dividend and quotient width (>=2).
- VW, 4, divisor and remainder width (1..DW).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle, can accept operands
- dividend  in  DW  unsigned dividend
- divisor  in  VW  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  DW  unsigned quotient
- remainder  out  VW  unsigned remainder
- div0  out  1  divisor was zero (see Optional Feature)
- busy  out  1  high in BUSY state

Behaviour:
- Reset is asynchronous, active-high. While reset is high:
  - state=IDLE
  - in_ready=1 (asserted from reset release onward)
  - out_valid=0, quotient=0, remainder=0, div0=0, busy=0
  - internal step counter=0, partial remainder=0
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch dividend into shift register, divisor into a register, clear partial remainder R (VW+1 bits), load counter=DW-1, go BUSY.
  - Operands are sampled only at that edge.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge: R' = {R[VW-1:0], dividend MSB}; shift dividend left.
  - If R' >= {1'b0,divisor}: R = R' - divisor, shifted-in quotient bit = 1. Else R = R', bit = 0.
  - After DW steps (counter reaches 0 on the last step), go DONE.
- DONE:
  - quotient and remainder are registered; remainder = R[VW-1:0]; out_valid=1.
  - Outputs held stable while out_ready=0, for arbitrarily long.
  - On out_valid&out_ready: out_valid falls next edge, go IDLE.
  - quotient/remainder keep their last values until the next result.
- Latency: accept edge k -> out_valid high after edge k+DW (default 8 cycles).
- Throughput: one operation per DW+2 cycles minimum.
- in_ready=0 in DONE; no same-cycle accept on the handshake-out edge.
- in_valid while busy is ignored; the upstream must hold it.
- Divisor=0 without trap: every step subtracts 0, so quotient = all ones and remainder = dividend[VW-1:0]. These values are required and deterministic.
- Reset mid-operation: everything aborts immediately to reset values; no partial result is ever presented.
- Invariant at every out_valid: dividend == quotient*divisor + remainder, and remainder < divisor (for divisor != 0).

Optional Feature:
- Macro DIVIDER_DIV0_TRAP_EN.
- Defined:
  - Accepting divisor==0 skips BUSY and goes DONE on the next edge (latency 1).
  - quotient = all ones, remainder = dividend[VW-1:0], div0=1.
  - div0 clears when that result is handshaken out.
- Undefined:
  - div0 is tied 0.
  - Divisor 0 runs the full DW steps, producing the same quotient/remainder values.

Decomposition:
- Package divider_pkg holds:
  - state enum (IDLE, BUSY, DONE)
  - default width constants DIV_DW=8, DIV_VW=4
  - counter width localparam: clog2(DW)
- One natural sub-module: divider_step. It is combinational: takes R, next dividend bit and divisor; returns new R and quotient bit.
- Top level holds the FSM, counter and registers.

Test Plan:
- Basic divides, out_ready=1: 200/7 -> quotient=28, remainder=4, out_valid 8 cycles after accept; 255/15 -> 17, 0; 5/9 -> 0, 5.
- Divisor 0: 100/0 -> quotient=255, remainder=4.
  - With DIVIDER_DIV0_TRAP_EN: div0=1, latency 1.
  - Without: div0=0, latency 8.
- Backpressure: 77/3, hold out_ready=0 for 5 cycles after out_valid -> quotient=25, remainder=2 held stable; in_ready stays 0; release -> IDLE next edge.
- in_valid held continuously with new operands on each accept (back-to-back): each result is correct; accepts are spaced exactly 10 cycles apart; no operand is sampled while BUSY/DONE.
- Reset pulse on 4th BUSY cycle of 123/5: all outputs return to reset values asynchronously. Next op 9/2 -> quotient=4, remainder=1; no stale bits.
- Random sweep, 2000 ops over full 8/4 range with random out_ready stalls: quotient*divisor+remainder==dividend and remainder<divisor for every result.
